// File: rtl/lockpick_host.sv
// Initiator for the lockpick game core: takes one key-pair attempt, streams the
// key bytes to the core, collects the result stream and reports one record.
module lockpick_host #(
    parameter int unsigned NBYTES       = 32,
    parameter int unsigned BYTE_GAP     = 0,
    parameter int unsigned RESP_TIMEOUT = 64   // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [NBYTES*8-1:0]   cmd_key_a,
    input  logic [NBYTES*8-1:0]   cmd_key_b,
    output logic                  start,
    output logic                  input_enable,
    output logic [7:0]            input_data,
    input  logic                  output_valid,
    input  logic [7:0]            output_data,
    input  logic [1:0]            status,
    output logic                  res_valid,
    output logic [1:0]            res_status,
    output logic [NBYTES*8-1:0]   res_msg,
    output logic                  res_msg_ok,
    output logic                  res_timeout,
    output logic                  need_start
);

    localparam int unsigned KeyW  = NBYTES * 8;
    localparam int unsigned GapW  = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int unsigned RespW = $clog2(RESP_TIMEOUT + 1);

    localparam logic [4:0]       LastByte = 5'(NBYTES - 1);
    localparam logic [GapW-1:0]  GapLoad  = GapW'(BYTE_GAP);
    // WAIT_RESP is entered the cycle after the last key byte with the counter at 0,
    // so leaving at RESP_TIMEOUT-2 puts DONE exactly RESP_TIMEOUT cycles after it.
    localparam logic [RespW-1:0] RespLast = RespW'(RESP_TIMEOUT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSendA,
        StSendB,
        StWaitResp,
        StRecv,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [RespW-1:0]  resp_cnt_q, resp_cnt_d;
    logic [4:0]        rx_cnt_q, rx_cnt_d;
    logic [KeyW-1:0]   key_a_q, key_a_d;
    logic [KeyW-1:0]   key_b_q, key_b_d;
    logic [KeyW-1:0]   msg_q, msg_d;
    logic [1:0]        stat_q, stat_d;
    logic              need_start_q, need_start_d;
    logic [1:0]        res_status_q, res_status_d;
    logic [KeyW-1:0]   res_msg_q, res_msg_d;
    logic              res_timeout_q, res_timeout_d;
    logic              finish;
    logic              timed_out;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            resp_cnt_q    <= '0;
            rx_cnt_q      <= '0;
            key_a_q       <= '0;
            key_b_q       <= '0;
            msg_q         <= '0;
            stat_q        <= '0;
            need_start_q  <= 1'b1;
            res_status_q  <= '0;
            res_msg_q     <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            resp_cnt_q    <= resp_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            key_a_q       <= key_a_d;
            key_b_q       <= key_b_d;
            msg_q         <= msg_d;
            stat_q        <= stat_d;
            need_start_q  <= need_start_d;
            res_status_q  <= res_status_d;
            res_msg_q     <= res_msg_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Next-state logic and game-core strobes.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        resp_cnt_d    = resp_cnt_q;
        rx_cnt_d      = rx_cnt_q;
        key_a_d       = key_a_q;
        key_b_d       = key_b_q;
        msg_d         = msg_q;
        stat_d        = stat_q;
        need_start_d  = need_start_q;
        res_status_d  = res_status_q;
        res_msg_d     = res_msg_q;
        res_timeout_d = res_timeout_q;
        cmd_ready     = 1'b0;
        start         = 1'b0;
        input_enable  = 1'b0;
        input_data    = 8'h00;
        res_valid     = 1'b0;
        finish        = 1'b0;
        timed_out     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    key_a_d    = cmd_key_a;
                    key_b_d    = cmd_key_b;
                    msg_d      = '0;
                    stat_d     = '0;
                    byte_cnt_d = '0;
                    gap_cnt_d  = '0;
                    rx_cnt_d   = '0;
                    resp_cnt_d = '0;
                    state_d    = need_start_q ? StStart : StSendA;
                end
            end
            StStart: begin
                start        = 1'b1;
                need_start_d = 1'b0;
                state_d      = StSendA;
            end
            StSendA: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else begin
                    input_enable = 1'b1;
                    input_data   = key_a_q[{byte_cnt_q, 3'b000} +: 8];
                    gap_cnt_d    = GapLoad;
                    byte_cnt_d   = byte_cnt_q + 5'd1;
                    if (byte_cnt_q == LastByte) begin
                        byte_cnt_d = '0;
                        state_d    = StSendB;
                    end
                end
            end
            StSendB: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else begin
                    input_enable = 1'b1;
                    input_data   = key_b_q[{byte_cnt_q, 3'b000} +: 8];
                    gap_cnt_d    = GapLoad;
                    byte_cnt_d   = byte_cnt_q + 5'd1;
                    if (byte_cnt_q == LastByte) begin
                        // No gap after the final key byte.
                        byte_cnt_d = '0;
                        gap_cnt_d  = '0;
                        resp_cnt_d = '0;
                        state_d    = StWaitResp;
                    end
                end
            end
            StWaitResp, StRecv: begin
                // The first beat may arrive while still waiting; it is byte 0.
                if (output_valid) begin
                    msg_d[{rx_cnt_q, 3'b000} +: 8] = output_data;
                    if (rx_cnt_q == 5'd0) begin
                        stat_d = status;
                    end
                    rx_cnt_d = rx_cnt_q + 5'd1;
                    state_d  = StRecv;
                    if (rx_cnt_q == LastByte) begin
                        rx_cnt_d = '0;
                        state_d  = StDone;
                        finish   = 1'b1;
                    end
                end else if (state_q == StWaitResp) begin
                    if (resp_cnt_q == RespLast) begin
                        state_d   = StDone;
                        finish    = 1'b1;
                        timed_out = 1'b1;
                    end else begin
                        resp_cnt_d = resp_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                res_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Result record is published on entry to DONE and then held.
        if (finish) begin
            res_timeout_d = timed_out;
            res_status_d  = timed_out ? 2'b00 : stat_d;
            res_msg_d     = timed_out ? '0 : msg_d;
            // Win or lockout ends the game; error re-enters key entry by itself.
            if (timed_out || stat_d[1]) begin
                need_start_d = 1'b1;
            end
        end
    end

    // Expected-pattern check on the published message.
    always_comb begin
        logic [31:0] pat;
        unique case (res_status_q)
            2'b01:   pat = 32'hBAD0_BAD0;
            2'b10:   pat = 32'hFACE_FACE;
            2'b11:   pat = 32'hDEAD_DEAD;
            default: pat = 32'h0000_0000;
        endcase
        res_msg_ok = (res_status_q != 2'b00);
        for (int i = 0; i < int'(NBYTES / 4); i++) begin
            if (res_msg_q[32*i +: 32] != pat) begin
                res_msg_ok = 1'b0;
            end
        end
    end

    assign res_status  = res_status_q;
    assign res_msg     = res_msg_q;
    assign res_timeout = res_timeout_q;
    assign need_start  = need_start_q;

endmodule

// File: tb/tb_lockpick_host.sv
// Self-checking bench for lockpick_host: table of attempts against a small game
// model, plus a hand-written BYTE_GAP=2 / mid-attempt reset sequence.
module tb_lockpick_host;

    localparam int NB = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with BYTE_GAP = 0
    logic         rst, cmd_valid, cmd_ready, start, input_enable, output_valid;
    logic [255:0] cmd_key_a, cmd_key_b, res_msg;
    logic [7:0]   input_data, output_data;
    logic [1:0]   status, res_status;
    logic         res_valid, res_msg_ok, res_timeout, need_start;

    // DUT with BYTE_GAP = 2
    logic         rst_g, cmd_valid_g, cmd_ready_g, start_g, input_enable_g, output_valid_g;
    logic [255:0] cmd_key_a_g, cmd_key_b_g, res_msg_g;
    logic [7:0]   input_data_g, output_data_g;
    logic [1:0]   status_g, res_status_g;
    logic         res_valid_g, res_msg_ok_g, res_timeout_g, need_start_g;

    lockpick_host #(.NBYTES(NB), .BYTE_GAP(0), .RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key_a(cmd_key_a), .cmd_key_b(cmd_key_b), .start(start),
        .input_enable(input_enable), .input_data(input_data),
        .output_valid(output_valid), .output_data(output_data), .status(status),
        .res_valid(res_valid), .res_status(res_status), .res_msg(res_msg),
        .res_msg_ok(res_msg_ok), .res_timeout(res_timeout), .need_start(need_start)
    );

    lockpick_host #(.NBYTES(NB), .BYTE_GAP(2), .RESP_TIMEOUT(TO)) dut_gap (
        .clk(clk), .rst(rst_g), .cmd_valid(cmd_valid_g), .cmd_ready(cmd_ready_g),
        .cmd_key_a(cmd_key_a_g), .cmd_key_b(cmd_key_b_g), .start(start_g),
        .input_enable(input_enable_g), .input_data(input_data_g),
        .output_valid(output_valid_g), .output_data(output_data_g), .status(status_g),
        .res_valid(res_valid_g), .res_status(res_status_g), .res_msg(res_msg_g),
        .res_msg_ok(res_msg_ok_g), .res_timeout(res_timeout_g), .need_start(need_start_g)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [255:0] key_a;
        logic [255:0] key_b;
        logic [1:0]   kind;        // status the game model returns; 0 = silent
        bit           corrupt;     // flip one message byte
        bit           gappy;       // drop output_valid on some cycles
        bit           noise;       // stray output_valid / cmd_valid mid-attempt
        bit           exp_start;
        logic [1:0]   exp_status;
        bit           exp_ok;
        bit           exp_timeout;
        bit           exp_need;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [1:0] kind, input bit corrupt, input bit gappy,
                                input bit noise, input bit es, input logic [1:0] st,
                                input bit ok, input bit to, input bit need);
        vec_t v;
        v.key_a = '0; v.key_b = '0;
        v.kind = kind; v.corrupt = corrupt; v.gappy = gappy; v.noise = noise;
        v.exp_start = es; v.exp_status = st; v.exp_ok = ok; v.exp_timeout = to;
        v.exp_need = need;
        return v;
    endfunction

    function automatic logic [255:0] pat_msg(input logic [1:0] kind);
        logic [31:0] w;
        case (kind)
            2'b01:   w = 32'hBAD0BAD0;
            2'b10:   w = 32'hFACEFACE;
            2'b11:   w = 32'hDEADDEAD;
            default: w = 32'h0;
        endcase
        return {8{w}};
    endfunction

    task automatic run_attempt(input int idx);
        vec_t         v;
        logic [255:0] msg, exp_msg;
        logic [7:0]   eb;
        int k, nstb, first_k, last_k, start_k, done_k, beat;
        int byte_err, proto_err, ready_err;
        string tag;
        v = vecs[idx];
        msg = pat_msg(v.kind);
        if (v.corrupt) msg[47:40] = msg[47:40] ^ 8'h01;
        exp_msg = v.exp_timeout ? '0 : msg;
        k = 0; nstb = 0; first_k = 0; last_k = 0; start_k = 0; done_k = 0; beat = 0;
        byte_err = 0; proto_err = 0; ready_err = 0;
        tag = $sformatf("att%0d", idx);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_key_a = v.key_a; cmd_key_b = v.key_b;
        while (done_k == 0 && k < 600) begin
            @(negedge clk);
            k++;
            if (k == 1) cmd_valid = 1'b0;
            if (start && start_k == 0) start_k = k;
            if (start && input_enable) proto_err++;
            if (!input_enable && input_data != 8'h00) proto_err++;
            if (cmd_ready) ready_err++;
            if (input_enable) begin
                eb = (nstb < NB) ? v.key_a[8*nstb +: 8] : v.key_b[8*(nstb-NB) +: 8];
                if (input_data !== eb) byte_err++;
                if (nstb == 0) first_k = k;
                last_k = k;
                nstb++;
            end
            if (res_valid) done_k = k;
            output_valid = 1'b0; output_data = 8'h00; status = 2'b00;
            if (v.noise && nstb == 10 && input_enable) begin
                output_valid = 1'b1; output_data = 8'hEE; status = 2'b10;
            end
            if (v.noise && nstb == 2*NB && k == last_k + 1) cmd_valid = 1'b1;
            if (v.noise && nstb == 2*NB && k == last_k + 3) cmd_valid = 1'b0;
            if (v.kind != 2'b00 && nstb == 2*NB && k >= last_k + 3 && beat < NB && done_k == 0)
            begin
                if (!(v.gappy && (k % 4 == 0))) begin
                    output_valid = 1'b1;
                    output_data  = msg[8*beat +: 8];
                    status       = v.kind;
                    beat++;
                end
            end
        end
        output_valid = 1'b0; output_data = 8'h00; status = 2'b00; cmd_valid = 1'b0;

        check({tag, ".start_cycle"}, start_k, v.exp_start ? 1 : 0);
        check({tag, ".first_strobe"}, first_k, v.exp_start ? 2 : 1);
        check({tag, ".strobes"}, nstb, 2*NB);
        check({tag, ".strobe_span"}, last_k - first_k + 1, 2*NB);
        check({tag, ".key_bytes"}, byte_err, 0);
        check({tag, ".strobe_rules"}, proto_err, 0);
        check({tag, ".ready_busy"}, ready_err, 0);
        check({tag, ".res_valid_seen"}, done_k != 0, 1);
        check({tag, ".res_status"}, res_status, v.exp_status);
        check({tag, ".res_msg"}, res_msg, exp_msg);
        check({tag, ".res_msg_ok"}, res_msg_ok, v.exp_ok);
        check({tag, ".res_timeout"}, res_timeout, v.exp_timeout);
        check({tag, ".need_start"}, need_start, v.exp_need);
        if (v.exp_timeout) check({tag, ".timeout_latency"}, done_k - last_k, TO);
        @(negedge clk);
        check({tag, ".res_valid_pulse"}, res_valid, 0);
        check({tag, ".ready_after"}, cmd_ready, 1);
        check({tag, ".res_msg_held"}, res_msg, exp_msg);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        check({tag, ".need_start"}, need_start, 1);
        check({tag, ".start"}, start, 0);
        check({tag, ".input_enable"}, input_enable, 0);
        check({tag, ".input_data"}, input_data, 0);
        check({tag, ".res_valid"}, res_valid, 0);
        check({tag, ".res_status"}, res_status, 0);
        check({tag, ".res_msg"}, res_msg, 0);
        check({tag, ".res_msg_ok"}, res_msg_ok, 0);
        check({tag, ".res_timeout"}, res_timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ka, kb;
        logic [7:0]   eb;
        int k, nstb, byte_err, rv_cnt, done_k;
        int stk[64];

        rst = 1'b1; cmd_valid = 1'b0; cmd_key_a = '0; cmd_key_b = '0;
        output_valid = 1'b0; output_data = 8'h00; status = 2'b00;
        rst_g = 1'b1; cmd_valid_g = 1'b0; cmd_key_a_g = '0; cmd_key_b_g = '0;
        output_valid_g = 1'b0; output_data_g = 8'h00; status_g = 2'b00;

        //                 kind   cor  gap  noi  st  exp_st ok to need
        vecs[0] = mk(2'b01, 0,   0,   0,   1,  2'b01, 1, 0, 0);
        vecs[1] = mk(2'b01, 0,   0,   1,   0,  2'b01, 1, 0, 0);
        vecs[2] = mk(2'b01, 0,   0,   0,   0,  2'b01, 1, 0, 0);
        vecs[3] = mk(2'b11, 0,   0,   0,   0,  2'b11, 1, 0, 1);
        vecs[4] = mk(2'b10, 0,   0,   0,   1,  2'b10, 1, 0, 1);
        vecs[5] = mk(2'b01, 1,   1,   0,   1,  2'b01, 0, 0, 0);
        vecs[6] = mk(2'b00, 0,   0,   0,   0,  2'b00, 0, 1, 1);
        vecs[7] = mk(2'b01, 0,   1,   1,   1,  2'b01, 1, 0, 0);
        for (int i = 1; i < 8; i++) begin
            for (int j = 0; j < NB; j++) begin
                ka[8*j +: 8] = 8'(j*7 + i*13 + 1);
                kb[8*j +: 8] = 8'(8'hF0 - j*5 + i);
            end
            vecs[i].key_a = ka;
            vecs[i].key_b = kb;
        end

        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        rst = 1'b0; rst_g = 1'b0;
        @(negedge clk);
        check_reset_state("rst_released");

        for (int i = 0; i < 8; i++) run_attempt(i);

        // BYTE_GAP = 2, reset in the middle of key B.
        for (int j = 0; j < NB; j++) begin
            ka[8*j +: 8] = 8'(j + 8'h40);
            kb[8*j +: 8] = 8'(j + 8'h80);
        end
        @(negedge clk);
        cmd_valid_g = 1'b1; cmd_key_a_g = ka; cmd_key_b_g = kb;
        k = 0; nstb = 0; byte_err = 0;
        while (nstb < 40 && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) cmd_valid_g = 1'b0;
            if (input_enable_g) begin
                eb = (nstb < NB) ? ka[8*nstb +: 8] : kb[8*(nstb-NB) +: 8];
                if (input_data_g !== eb) byte_err++;
                stk[nstb] = k;
                nstb++;
            end
        end
        check("gap.reached_b", nstb, 40);
        check("gap.first_strobe", stk[0], 2);
        check("gap.spacing", stk[1] - stk[0], 3);
        check("gap.spacing_a_to_b", stk[32] - stk[31], 3);
        check("gap.key_bytes", byte_err, 0);
        rst_g = 1'b1;
        #1;
        check("gap.rst_input_enable", input_enable_g, 0);
        check("gap.rst_input_data", input_data_g, 0);
        check("gap.rst_cmd_ready", cmd_ready_g, 1);
        check("gap.rst_need_start", need_start_g, 1);
        repeat (2) @(negedge clk);
        rst_g = 1'b0;
        rv_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (res_valid_g) rv_cnt++;
        end
        check("gap.no_res_after_rst", rv_cnt, 0);

        // Next attempt after reset: start pulse, full gapped stream, timeout.
        @(negedge clk);
        cmd_valid_g = 1'b1;
        k = 0; nstb = 0; byte_err = 0; done_k = 0; rv_cnt = 0;
        while (done_k == 0 && k < 600) begin
            @(negedge clk);
            k++;
            if (k == 1) cmd_valid_g = 1'b0;
            if (start_g) rv_cnt = k;
            if (input_enable_g) begin
                eb = (nstb < NB) ? ka[8*nstb +: 8] : kb[8*(nstb-NB) +: 8];
                if (input_data_g !== eb) byte_err++;
                if (nstb < 64) stk[nstb] = k;
                nstb++;
            end
            if (res_valid_g) done_k = k;
        end
        check("gap2.start_cycle", rv_cnt, 1);
        check("gap2.strobes", nstb, 64);
        check("gap2.first_strobe", stk[0], 2);
        check("gap2.total_span", stk[63] - stk[0], 63*3);
        check("gap2.key_bytes", byte_err, 0);
        check("gap2.timeout_latency", done_k - stk[63], TO);
        check("gap2.res_timeout", res_timeout_g, 1);
        check("gap2.res_status", res_status_g, 0);
        check("gap2.res_msg", res_msg_g, 0);
        check("gap2.need_start", need_start_g, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
